// File: rtl/instruction_buffer_unit_pkg.sv
// Shared constants for the instruction buffer: default width, bubble word and
// RV32 field bit positions used by the slicer.
package instruction_buffer_unit_pkg;

  localparam int          ILEN_DEF     = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNC3_LSB  = 12;
  localparam int FUNC3_MSB  = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNC7_LSB  = 25;
  localparam int FUNC7_MSB  = 31;

endpackage

// File: rtl/instruction_buffer_unit_slicer.sv
// Combinational split of one instruction word into its decode fields.
module inst_field_slicer
  import instruction_buffer_unit_pkg::*;
#(
  parameter int ILEN = ILEN_DEF
) (
  input  logic [ILEN-1:0] inst,
  output logic [6:0]      opcode,
  output logic [4:0]      rd_addr,
  output logic [2:0]      func3,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [6:0]      func7,
  output logic [24:0]     instr_31_to_7
);

  assign opcode        = inst[OPCODE_MSB:OPCODE_LSB];
  assign rd_addr       = inst[RD_MSB:RD_LSB];
  assign func3         = inst[FUNC3_MSB:FUNC3_LSB];
  assign rs1_addr      = inst[RS1_MSB:RS1_LSB];
  assign rs2_addr      = inst[RS2_MSB:RS2_LSB];
  assign func7         = inst[FUNC7_MSB:FUNC7_LSB];
  assign instr_31_to_7 = inst[FUNC7_MSB:RD_LSB];

endmodule

// File: rtl/instruction_buffer_unit.sv
// Fetch-to-decode instruction FIFO with a registered, pre-sliced output stage
// that presents a bubble on underflow, flush and reset.
module instruction_buffer_unit
  import instruction_buffer_unit_pkg::*;
#(
  parameter int               ILEN     = ILEN_DEF,
  parameter int               DEPTH    = 4,
  parameter logic [ILEN-1:0]  NOP_INST = NOP_INST_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     inst_valid_in,
  input  logic [ILEN-1:0]          inst_in,
  input  logic [ILEN-1:0]          pc_in,
  output logic                     inst_ready_out,
  input  logic                     flush_in,
  input  logic                     stall_in,
  output logic                     dec_valid_out,
  output logic [6:0]               opcode_out,
  output logic [4:0]               rd_addr_out,
  output logic [2:0]               func3_out,
  output logic [4:0]               rs1_addr_out,
  output logic [4:0]               rs2_addr_out,
  output logic [6:0]               func7_out,
  output logic [24:0]              instr_31_to_7_out,
  output logic [ILEN-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [2*ILEN-1:0] mem_p0 [DEPTH];
  logic [2*ILEN-1:0] head_p0;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              wr_en, rd_en, load_out;
  logic [ILEN-1:0]   nxt_inst, nxt_pc;

  logic [6:0]        sl_opcode, sl_func7;
  logic [4:0]        sl_rd, sl_rs1, sl_rs2;
  logic [2:0]        sl_func3;
  logic [24:0]       sl_hi;

  logic              vld_p1;
  logic [6:0]        opcode_p1, func7_p1;
  logic [4:0]        rd_p1, rs1_p1, rs2_p1;
  logic [2:0]        func3_p1;
  logic [24:0]       hi_p1;
  logic [ILEN-1:0]   pc_p1;

  // Full blocks writes even when a read frees a slot in the same cycle.
  assign inst_ready_out = (count < DEPTH_C) && !flush_in;
  assign wr_en          = inst_valid_in && inst_ready_out && rst_n_in;
  assign rd_en          = !stall_in && !flush_in && (count != '0);
  assign load_out       = !rst_n_in || flush_in || !stall_in;
  assign head_p0        = mem_p0[rd_ptr];

  always_comb begin
    nxt_inst = NOP_INST;
    nxt_pc   = '0;
    if (rst_n_in && rd_en) begin
      nxt_inst = head_p0[2*ILEN-1:ILEN];
      nxt_pc   = head_p0[ILEN-1:0];
    end
  end

  inst_field_slicer #(.ILEN(ILEN)) u_slicer (
    .inst          (nxt_inst),
    .opcode        (sl_opcode),
    .rd_addr       (sl_rd),
    .func3         (sl_func3),
    .rs1_addr      (sl_rs1),
    .rs2_addr      (sl_rs2),
    .func7         (sl_func7),
    .instr_31_to_7 (sl_hi)
  );

  // Stage p0: storage, pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (wr_en) mem_p0[wr_ptr] <= {inst_in, pc_in};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!stall_in) vld_p1 <= rd_en;
    end
  end

  // Stage p1: registered decode fields of one selected word
  always_ff @(posedge clk_in) begin
    if (load_out) begin
      opcode_p1 <= sl_opcode;
      rd_p1     <= sl_rd;
      func3_p1  <= sl_func3;
      rs1_p1    <= sl_rs1;
      rs2_p1    <= sl_rs2;
      func7_p1  <= sl_func7;
      hi_p1     <= sl_hi;
      pc_p1     <= nxt_pc;
    end
  end

  assign dec_valid_out     = vld_p1;
  assign opcode_out        = opcode_p1;
  assign rd_addr_out       = rd_p1;
  assign func3_out         = func3_p1;
  assign rs1_addr_out      = rs1_p1;
  assign rs2_addr_out      = rs2_p1;
  assign func7_out         = func7_p1;
  assign instr_31_to_7_out = hi_p1;
  assign pc_out            = pc_p1;
  assign count_out         = count;

endmodule

// File: tb/tb_instruction_buffer_unit.sv
// Directed bench for instruction_buffer_unit (DEPTH=4) with hand-computed expectations.
module tb_instruction_buffer_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] pc = '0;
  logic        inst_ready;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        dec_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd_addr;
  logic [2:0]  func3;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [6:0]  func7;
  logic [24:0] hi;
  logic [31:0] pc_o;
  logic [2:0]  count;
  logic [31:0] obs_word;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] w_tab [5];
  logic [31:0] p_tab [5];

  always #5 clk = ~clk;

  instruction_buffer_unit dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .inst_valid_in     (inst_valid),
    .inst_in           (inst),
    .pc_in             (pc),
    .inst_ready_out    (inst_ready),
    .flush_in          (flush),
    .stall_in          (stall),
    .dec_valid_out     (dec_valid),
    .opcode_out        (opcode),
    .rd_addr_out       (rd_addr),
    .func3_out         (func3),
    .rs1_addr_out      (rs1_addr),
    .rs2_addr_out      (rs2_addr),
    .func7_out         (func7),
    .instr_31_to_7_out (hi),
    .pc_out            (pc_o),
    .count_out         (count)
  );

  assign obs_word = {func7, rs2_addr, rs1_addr, func3, rd_addr, opcode};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inst_valid = 1'b1; inst = 32'hFFFF_FFFF; pc = 32'h44; flush = 1'b1; stall = 1'b1;
    tick(); tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", dec_valid); end
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", pc_o); end
    n_checks++; if (obs_word !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_fields got %h exp 00000013", obs_word); end
    n_checks++; if (hi !== 25'h0) begin n_fail++; $display("FAIL rst_hi got %h exp 0", hi); end
    rst_n = 1'b1; inst_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    #1;
    n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", inst_ready); end
  endtask

  task automatic test_latency();
    inst_valid = 1'b1; inst = 32'h00A0_0093; pc = 32'h100;
    tick();
    inst_valid = 1'b0;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid got %b exp 0", dec_valid); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL lat_count1 got %0d exp 1", count); end
    tick();
    n_checks++; if (opcode !== 7'h13) begin n_fail++; $display("FAIL lat_opcode got %h exp 13", opcode); end
    n_checks++; if (rd_addr !== 5'd1) begin n_fail++; $display("FAIL lat_rd got %0d exp 1", rd_addr); end
    n_checks++; if (rs2_addr !== 5'd10) begin n_fail++; $display("FAIL lat_rs2 got %0d exp 10", rs2_addr); end
    n_checks++; if (hi !== 25'h0014001) begin n_fail++; $display("FAIL lat_hi got %h exp 0014001", hi); end
    n_checks++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL lat_pc got %h exp 100", pc_o); end
    n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b exp 1", dec_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL lat_count0 got %0d exp 0", count); end
    tick();
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL under_valid got %b exp 0", dec_valid); end
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL under_pc got %h exp 0", pc_o); end
    n_checks++; if (obs_word !== 32'h0000_0013) begin n_fail++; $display("FAIL under_fields got %h exp 00000013", obs_word); end
  endtask

  task automatic test_stall_full();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst_valid = 1'b1; inst = w_tab[i]; pc = p_tab[i];
      #1;
      if (i == 4) begin
        n_checks++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", inst_ready); end
      end
      tick();
      if (i == 3) begin
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
      end
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_no_ovf got %0d exp 4", count); end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL stall_frozen got %b exp 0", dec_valid); end
    // release stall while still offering the 5th word: full blocks it this edge
    stall = 1'b0;
    tick();
    inst_valid = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL no_passthru got %0d exp 3", count); end
    n_checks++; if (obs_word !== w_tab[0]) begin n_fail++; $display("FAIL drain_word0 got %h exp %h", obs_word, w_tab[0]); end
    n_checks++; if (pc_o !== p_tab[0]) begin n_fail++; $display("FAIL drain_pc0 got %h exp %h", pc_o, p_tab[0]); end
    n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid got %b exp 1", dec_valid); end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_checks++; if (obs_word !== w_tab[i]) begin n_fail++; $display("FAIL drain_word%0d got %h exp %h", i, obs_word, w_tab[i]); end
      n_checks++; if (pc_o !== p_tab[i]) begin n_fail++; $display("FAIL drain_pc%0d got %h exp %h", i, pc_o, p_tab[i]); end
    end
    tick();
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", dec_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_valid = 1'b1; inst = w_tab[i]; pc = p_tab[i];
      tick();
    end
    inst_valid = 1'b0; stall = 1'b0;
    tick();
    stall = 1'b1; inst_valid = 1'b1; inst = w_tab[3]; pc = p_tab[3];
    tick();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fl_pre_count got %0d exp 3", count); end
    n_checks++; if (obs_word !== w_tab[0]) begin n_fail++; $display("FAIL fl_pre_word got %h exp %h", obs_word, w_tab[0]); end
    inst = w_tab[4]; pc = p_tab[4]; flush = 1'b1;
    #1;
    n_checks++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %b exp 0", inst_ready); end
    tick();
    flush = 1'b0; inst_valid = 1'b0; stall = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fl_count got %0d exp 0", count); end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %b exp 0", dec_valid); end
    n_checks++; if (opcode !== 7'h13) begin n_fail++; $display("FAIL fl_opcode got %h exp 13", opcode); end
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL fl_pc got %h exp 0", pc_o); end
    tick();
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL fl_dropped got %b exp 0", dec_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fl_after_count got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sw [12];
    logic [31:0] sp [12];
    for (int i = 0; i < 12; i++) begin
      sw[i] = {7'h00, 5'(i), 5'(i + 1), 3'h0, 5'(i), 7'h33};
      sp[i] = 32'h400 + 32'(4 * i);
    end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inst_valid = 1'b1; inst = sw[i]; pc = sp[i];
      tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inst_valid = 1'b1; inst = sw[i + 2]; pc = sp[i + 2];
      tick();
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count%0d got %0d exp 2", i, count); end
      n_checks++; if (obs_word !== sw[i] || pc_o !== sp[i]) begin
        n_fail++; $display("FAIL b2b_order%0d got %h@%h exp %h@%h", i, obs_word, pc_o, sw[i], sp[i]);
      end
    end
    inst_valid = 1'b0;
    for (int i = 10; i < 12; i++) begin
      tick();
      n_checks++; if (obs_word !== sw[i] || dec_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_tail%0d got %h v%b exp %h v1", i, obs_word, dec_valid, sw[i]);
      end
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_final_count got %0d exp 0", count); end
  endtask

  task automatic test_reset_midstream();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_valid = 1'b1; inst = w_tab[i]; pc = 32'h800 + 32'(4 * i);
      tick();
    end
    inst_valid = 1'b0; stall = 1'b0;
    tick();
    n_checks++; if (count !== 3'd2 || dec_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got count %0d v%b exp 2 v1", count, dec_valid);
    end
    rst_n = 1'b0; inst_valid = 1'b1; inst = w_tab[3]; pc = 32'h900;
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", count); end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", dec_valid); end
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL mid_pc got %h exp 0", pc_o); end
    n_checks++; if (obs_word !== 32'h0000_0013 || hi !== 25'h0) begin
      n_fail++; $display("FAIL mid_fields got %h/%h exp 00000013/0", obs_word, hi);
    end
    rst_n = 1'b1; inst_valid = 1'b0;
    tick();
    n_checks++; if (dec_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL mid_stale1 got v%b count %0d exp v0 count 0", dec_valid, count);
    end
    tick();
    n_checks++; if (dec_valid !== 1'b0 || pc_o !== 32'h0) begin
      n_fail++; $display("FAIL mid_stale2 got v%b pc %h exp v0 pc 0", dec_valid, pc_o);
    end
  endtask

  initial begin
    w_tab[0] = 32'h0020_8133; p_tab[0] = 32'h200;
    w_tab[1] = 32'h4041_8233; p_tab[1] = 32'h204;
    w_tab[2] = 32'h0062_A3B3; p_tab[2] = 32'h208;
    w_tab[3] = 32'hFE73_1CE3; p_tab[3] = 32'h20C;
    w_tab[4] = 32'h1234_5678; p_tab[4] = 32'h210;
    test_reset();
    test_latency();
    test_stall_full();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
